// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish on the accept edge. Shifts iterate one bit per
// cycle, and the optional multiplier runs one multiplier bit per cycle.
// Results, ZNCV flags and the invalid-opcode bit are registered and held
// until the consumer takes them.
module alu_mc #(
    parameter int N      = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_ctrl,
    input  logic [N-1:0] src_A,
    input  logic [N-1:0] src_B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_result,
    output logic [3:0]   alu_flags,
    output logic         alu_err
);

    localparam int SHW = $clog2(N);
    // One extra bit so the counter can hold N for the multiplier.
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_MOVE = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_MUL = 2'd2
    } kind_t;

    state_t         state_reg, state_next;
    kind_t          kind_reg;
    logic [N-1:0]   work_reg;
    logic [CW-1:0]  cnt_reg;
    logic           out_valid_reg;
    logic [N-1:0]   result_reg;
    logic [3:0]     flags_reg;
    logic           err_reg;

    // Request decode
    logic [SHW-1:0] shamt;
    logic           is_shift;
    logic           is_mul_op;
    logic           goes_exec;
    logic           load_iter;

    assign shamt     = src_B[SHW-1:0];
    assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL);
    assign is_mul_op = MUL_EN && (alu_ctrl == OP_MUL);
    // A zero-distance shift has nothing to iterate, so it completes like a
    // single-cycle op.
    assign goes_exec = (is_shift && (shamt != '0)) || is_mul_op;
    assign load_iter = in_valid && (state_reg == IDLE) && goes_exec;

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = out_valid_reg;
    assign alu_result = result_reg;
    assign alu_flags  = flags_reg;
    assign alu_err    = err_reg;

    // Single-cycle datapath
    logic [N:0]   add_ext;
    logic [N:0]   sub_ext;
    logic [N-1:0] sc_result;
    logic         sc_c;
    logic         sc_v;
    logic         sc_err;

    assign add_ext = {1'b0, src_A} + {1'b0, src_B};
    // The carry out of A + ~B + 1 is the no-borrow flag (A >= B unsigned).
    assign sub_ext = {1'b0, src_A} + {1'b0, ~src_B} + {{N{1'b0}}, 1'b1};

    // Result and C/V for every op that completes on the accept edge.
    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_err    = 1'b0;
        case (alu_ctrl)
            OP_AND:  sc_result = src_A & src_B;
            OP_XOR:  sc_result = src_A ^ src_B;
            OP_SUB: begin
                sc_result = sub_ext[N-1:0];
                sc_c      = sub_ext[N];
                sc_v      = (src_A[N-1] != src_B[N-1]) && (sub_ext[N-1] != src_A[N-1]);
            end
            OP_ADD: begin
                sc_result = add_ext[N-1:0];
                sc_c      = add_ext[N];
                sc_v      = (src_A[N-1] == src_B[N-1]) && (add_ext[N-1] != src_A[N-1]);
            end
            OP_MOVE: sc_result = src_B;
            OP_NOT:  sc_result = ~src_A;
            OP_OR:   sc_result = src_A | src_B;
            // Only reached with shamt == 0: the operand passes through, C = 0.
            OP_SLL, OP_SRL: sc_result = src_A;
            // Invalid opcodes, and MUL when the multiplier is not built.
            default: sc_err = 1'b1;
        endcase
    end

    // Iterative datapath
    logic [N-1:0] work_step;
    logic [N-1:0] iter_result;
    logic         iter_c;
    logic [N-1:0] acc_step;

    // One iteration step. In MUL the working register holds the
    // multiplicand, which moves left one place per step.
    always_comb begin
        work_step   = work_reg;
        iter_result = '0;
        iter_c      = 1'b0;
        case (kind_reg)
            K_SRL: begin
                work_step   = {1'b0, work_reg[N-1:1]};
                iter_c      = work_reg[0];
                iter_result = {1'b0, work_reg[N-1:1]};
            end
            K_MUL: begin
                work_step   = {work_reg[N-2:0], 1'b0};
                iter_result = acc_step;
            end
            default: begin
                work_step   = {work_reg[N-2:0], 1'b0};
                iter_c      = work_reg[N-1];
                iter_result = {work_reg[N-2:0], 1'b0};
            end
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            logic [N-1:0] acc_reg;
            logic [N-1:0] mplier_reg;

            // Shift-add: add the shifted multiplicand when the current
            // multiplier LSB is set, then consume that bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_reg    <= '0;
                    mplier_reg <= '0;
                end else if (load_iter) begin
                    acc_reg    <= '0;
                    mplier_reg <= src_B;
                end else if ((state_reg == EXEC) && (kind_reg == K_MUL)) begin
                    acc_reg    <= acc_step;
                    mplier_reg <= {1'b0, mplier_reg[N-1:1]};
                end
            end

            assign acc_step = acc_reg + (mplier_reg[0] ? work_reg : '0);
        end else begin : g_no_mul
            assign acc_step = '0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = goes_exec ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind_reg      <= K_SLL;
            work_reg      <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (goes_exec) begin
                            work_reg <= src_A;
                            if (is_mul_op) begin
                                kind_reg <= K_MUL;
                                cnt_reg  <= CW'(N);
                            end else begin
                                kind_reg <= (alu_ctrl == OP_SRL) ? K_SRL : K_SLL;
                                cnt_reg  <= {1'b0, shamt};
                            end
                        end else begin
                            result_reg    <= sc_result;
                            flags_reg     <= {(sc_result == '0), sc_result[N-1], sc_c, sc_v};
                            err_reg       <= sc_err;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    work_reg <= work_step;
                    cnt_reg  <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        result_reg    <= iter_result;
                        flags_reg     <= {(iter_result == '0), iter_result[N-1], iter_c, 1'b0};
                        err_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (N=32) with hand-written sequences
// for stall, reset-abort and the MUL-disabled variant.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_A, src_B;
    logic        out_valid, out_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        alu_err;

    logic        in_valid2, in_ready2, out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] alu_result2;
    logic [3:0]  alu_flags2;
    logic        alu_err2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mc #(.N(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .alu_flags(alu_flags), .alu_err(alu_err)
    );

    alu_mc #(.N(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
        .out_valid(out_valid2), .out_ready(out_ready2), .alu_result(alu_result2),
        .alu_flags(alu_flags2), .alu_err(alu_err2)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issue one op, wait for its result with out_ready low, check it, consume it.
    task automatic do_op(input vec_t v, input int idx);
        int  lat;
        bit  busy_ready;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({nm, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        alu_ctrl  = v.op;
        src_A     = v.a;
        src_B     = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        lat = 0;
        busy_ready = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Operands were captured on the accept edge; these must be ignored.
                in_valid = 1'b0;
                alu_ctrl = 4'd3;
                src_A    = 32'hDEAD_BEEF;
                src_B    = 32'h0000_0005;
            end
            if (!out_valid && in_ready) busy_ready = 1'b1;
        end while (!out_valid && lat < 200);
        $display("op=%0d a=%h b=%h -> res=%h flags=%b err=%b lat=%0d",
                 v.op, v.a, v.b, alu_result, alu_flags, alu_err, lat);
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " result"}, alu_result, v.res);
        chk({nm, " flags"}, {28'd0, alu_flags}, {28'd0, v.fl});
        chk({nm, " err"}, {31'd0, alu_err}, {31'd0, v.err});
        chk({nm, " in_ready_busy"}, {31'd0, busy_ready | in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({nm, " result_kept"}, alu_result, v.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'd0; src_A = '0; src_B = '0;

        //               op     a              b              lat res            fl       err
        vecs[0]  = '{4'd3,  32'h7FFF_FFFF, 32'h0000_0001, 1,  32'h8000_0000, 4'b0101, 1'b0};
        vecs[1]  = '{4'd2,  32'h0000_0005, 32'h0000_0005, 1,  32'h0000_0000, 4'b1010, 1'b0};
        vecs[2]  = '{4'd2,  32'h0000_0003, 32'h0000_0005, 1,  32'hFFFF_FFFE, 4'b0100, 1'b0};
        vecs[3]  = '{4'd8,  32'h8000_0001, 32'h0000_0004, 5,  32'h0800_0000, 4'b0000, 1'b0};
        vecs[4]  = '{4'd7,  32'h8000_0001, 32'h0000_0001, 2,  32'h0000_0002, 4'b0010, 1'b0};
        vecs[5]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0003, 33, 32'hFFFF_FFFD, 4'b0100, 1'b0};
        vecs[6]  = '{4'd12, 32'h1234_5678, 32'h0000_0009, 1,  32'h0000_0000, 4'b1000, 1'b1};
        vecs[7]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0000, 1,  32'h0000_0000, 4'b1000, 1'b0};
        vecs[8]  = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 1,  32'hF000_F000, 4'b0100, 1'b0};
        vecs[9]  = '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 1,  32'h0FF0_0FF0, 4'b0000, 1'b0};
        vecs[10] = '{4'd6,  32'h0F00_0000, 32'h0000_0001, 1,  32'h0F00_0001, 4'b0000, 1'b0};
        vecs[11] = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0000, 1,  32'h0000_0000, 4'b1000, 1'b0};
        vecs[12] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 4'b1010, 1'b0};
        vecs[13] = '{4'd2,  32'h8000_0000, 32'h0000_0001, 1,  32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[14] = '{4'd7,  32'h0000_1234, 32'h0000_0020, 1,  32'h0000_1234, 4'b0000, 1'b0};
        vecs[15] = '{4'd7,  32'h0000_0003, 32'h0000_001F, 32, 32'h8000_0000, 4'b0110, 1'b0};
        vecs[16] = '{4'd9,  32'd12345,     32'd1000,      33, 32'h00BC_5EA8, 4'b0000, 1'b0};
        vecs[17] = '{4'd15, 32'h0000_0001, 32'h0000_0001, 1,  32'h0000_0000, 4'b1000, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst result", alu_result, 32'd0);
        chk("rst flags", {28'd0, alu_flags}, 32'd0);
        chk("rst err", {31'd0, alu_err}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i], i);

        // MUL with a 3-cycle consumer stall, then simultaneous request and consume.
        @(negedge clk);
        alu_ctrl = 4'd9; src_A = 32'hFFFF_FFFF; src_B = 32'h3;
        in_valid = 1'b1; out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) in_valid = 1'b0;
        end while (!out_valid && lat < 200);
        $display("stall MUL -> res=%h flags=%b lat=%0d", alu_result, alu_flags, lat);
        chk("stall latency", lat, 33);
        chk("stall result", alu_result, 32'hFFFF_FFFD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall result_hold", alu_result, 32'hFFFF_FFFD);
            chk("stall flags_hold", {28'd0, alu_flags}, 32'h4);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        alu_ctrl = 4'd3; src_A = 32'd1; src_B = 32'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("simul consumed", {31'd0, out_valid}, 32'd0);
        chk("simul not_accepted", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("simul ADD -> res=%h flags=%b out_valid=%b", alu_result, alu_flags, out_valid);
        chk("simul next out_valid", {31'd0, out_valid}, 32'd1);
        chk("simul next result", alu_result, 32'd2);
        chk("simul next flags", {28'd0, alu_flags}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("simul drained", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a MUL aborts it without a result.
        @(negedge clk);
        alu_ctrl = 4'd9; src_A = 32'd7; src_B = 32'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset-abort -> out_valid=%b res=%h flags=%b in_ready=%b",
                 out_valid, alu_result, alu_flags, in_ready);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort result", alu_result, 32'd0);
        chk("abort flags", {28'd0, alu_flags}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        begin
            bit stale;
            stale = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid || !in_ready) stale = 1'b1;
            end
            chk("abort no_stale", {31'd0, stale}, 32'd0);
        end

        // Opcode 9 on the variant built without the multiplier.
        @(negedge clk);
        alu_ctrl = 4'd9; src_A = 32'd7; src_B = 32'd3; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        $display("nomul op=9 -> res=%h flags=%b err=%b valid=%b",
                 alu_result2, alu_flags2, alu_err2, out_valid2);
        chk("nomul out_valid", {31'd0, out_valid2}, 32'd1);
        chk("nomul result", alu_result2, 32'd0);
        chk("nomul flags", {28'd0, alu_flags2}, 32'h8);
        chk("nomul err", {31'd0, alu_err2}, 32'd1);
        @(negedge clk);
        chk("nomul in_ready", {31'd0, in_ready2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
